// File: rtl/z80_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_bridge
// Brief    : Converts Z80-style CPU strobes into a single req/ack transaction
//            toward the memory/IO fabric. It stretches CPU cycles with wait,
//            answers interrupt acknowledge locally, and aborts hung requests.
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [7:0]  IDLE_DATA   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_m1_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic [7:0]  int_vector,
  output logic        inta,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_INTA = 2'd3;

  // Counter value seen in the last REQ cycle before the abort fires.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_io_q, mem_io_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        inta_q, inta_d;
  logic        terr_q, terr_d;

  // Strobe decode; refresh cycles (rfsh_n low) never start a transaction.
  logic rd_cyc, wr_cyc, ack_cyc, strobe_any;
  assign rd_cyc     = ~cpu_rd_n & (~cpu_mreq_n | ~cpu_iorq_n) & cpu_rfsh_n;
  assign wr_cyc     = ~cpu_wr_n & (~cpu_mreq_n | ~cpu_iorq_n) & cpu_rfsh_n;
  assign ack_cyc    = ~cpu_m1_n & ~cpu_iorq_n;
  assign strobe_any = ~cpu_rd_n | ~cpu_wr_n | ~cpu_mreq_n | ~cpu_iorq_n;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Transaction latches, read-data register, timeout counter and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_io_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      data_q      <= IDLE_DATA;
      cnt_q       <= 16'h0000;
      inta_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_io_q    <= mem_io_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      inta_q      <= inta_d;
      terr_q      <= terr_d;
    end
  end

  // Next-state and datapath update; ack wins over timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_io_d    = mem_io_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    inta_d      = 1'b0;
    terr_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack_cyc) begin
          data_d  = int_vector;
          inta_d  = 1'b1;
          state_d = S_INTA;
        end else if (rd_cyc | wr_cyc) begin
          mem_addr_d  = cpu_a;
          mem_wdata_d = cpu_dout;
          mem_we_d    = wr_cyc;
          mem_io_d    = ~cpu_iorq_n;
          cnt_d       = 16'h0000;
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) data_d = mem_rdata;
          // A CPU that already let go of its strobes goes straight back to idle.
          state_d = strobe_any ? S_DONE : S_IDLE;
        end else if (cnt_q >= TO_LAST) begin
          mem_req_d = 1'b0;
          data_d    = IDLE_DATA;
          terr_d    = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'h0001;
        end
      end
      S_DONE, S_INTA: begin
        if (!strobe_any) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; wait is combinational so it appears with the strobe itself.
  always_comb begin
    cpu_di      = ((state_q == S_DONE) || (state_q == S_INTA)) ? data_q : IDLE_DATA;
    cpu_wait_n  = 1'b1;
    if (!reset) begin
      if (state_q == S_REQ)
        cpu_wait_n = 1'b0;
      else if ((state_q == S_IDLE) && (rd_cyc | wr_cyc) && !ack_cyc)
        cpu_wait_n = 1'b0;
    end
    mem_req     = mem_req_q;
    mem_we      = mem_we_q;
    mem_io      = mem_io_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    inta        = inta_q;
    timeout_err = terr_q;
  end

endmodule
`default_nettype wire
